// File: rtl/fmul_pipe_ctrl.sv
// Valid/ready controller for a 3-stage FP multiplier (partial product, add, normalize).
// Optional flush port is compiled in with FMUL_PIPE_FLUSH_EN.

module fmul_pipe_stage (
    input  logic clk,
    input  logic clrn,
    input  logic kill_i,
    input  logic v_up_i,
    input  logic rdy_dn_i,
    output logic v_o,
    output logic rdy_o
);
    logic v_q, v_d;

    // An empty stage always loads, which is what lets bubbles collapse.
    assign rdy_o = !v_q || rdy_dn_i;
    assign v_o   = v_q;

    always_comb begin
        v_d = v_q;
        if (kill_i)
            v_d = 1'b0;
        else if (rdy_o)
            v_d = v_up_i;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)
            v_q <= 1'b0;
        else
            v_q <= v_d;
    end
endmodule

module fmul_pipe_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clrn,
`ifdef FMUL_PIPE_FLUSH_EN
    input  logic             flush,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             e1,
    output logic             e2,
    output logic             e3,
    output logic [1:0]       occ,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int STAGES = 3;

    logic                kill;
    logic [STAGES:0]     vld_pipe;   // [0] is the upstream valid
    logic [STAGES+1:1]   rdy;        // [STAGES+1] is the downstream ready
    logic [CNT_W-1:0]    stall_q, stall_d;

`ifdef FMUL_PIPE_FLUSH_EN
    assign kill = flush;
`else
    assign kill = 1'b0;
`endif

    assign vld_pipe[0]    = in_valid;
    assign rdy[STAGES+1]  = out_ready;

    genvar k;
    generate
        for (k = 1; k <= STAGES; k++) begin : g_stg
            fmul_pipe_stage u_stg (
                .clk      (clk),
                .clrn     (clrn),
                .kill_i   (kill),
                .v_up_i   (vld_pipe[k-1]),
                .rdy_dn_i (rdy[k+1]),
                .v_o      (vld_pipe[k]),
                .rdy_o    (rdy[k])
            );
        end
    endgenerate

    // out_ready reaches in_ready purely combinationally; there is no skid buffer.
    assign in_ready  = rdy[1] && !kill;
    assign e1        = rdy[1] && !kill;
    assign e2        = rdy[2] && !kill;
    assign e3        = rdy[3] && !kill;
    assign out_valid = vld_pipe[STAGES];

    assign occ = {1'b0, vld_pipe[1]} + {1'b0, vld_pipe[2]} + {1'b0, vld_pipe[3]};

    always_comb begin
        stall_d = stall_q;
        if (vld_pipe[STAGES] && !out_ready && !kill && !(&stall_q))
            stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)
            stall_q <= '0;
        else
            stall_q <= stall_d;
    end

    assign stall_cnt = stall_q;
endmodule

// File: tb/tb_fmul_pipe_ctrl.sv
// Bench for fmul_pipe_ctrl: op-ID slot model checked every cycle, plus literal scenario checks.
module tb_fmul_pipe_ctrl;
    logic clk = 1'b0;
    logic clrn = 1'b0;
    logic flush = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic in_ready, out_valid, e1, e2, e3;
    logic [1:0] occ;
    logic [15:0] stall_cnt;
    logic s_in_ready, s_out_valid, s_e1, s_e2, s_e3;
    logic [1:0] s_occ;
    logic [3:0] s_stall_cnt;

    int checks = 0;
    int errors = 0;

    // Model: each stage slot holds an op ID, or -1 when empty.
    int slot [1:3];
    int stall = 0;
    int next_id = 0;
    int retire_exp = 0;
    int nov;

    always #5 clk = ~clk;

    fmul_pipe_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .clrn(clrn),
`ifdef FMUL_PIPE_FLUSH_EN
        .flush(flush),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid),
        .out_ready(out_ready), .e1(e1), .e2(e2), .e3(e3), .occ(occ),
        .stall_cnt(stall_cnt)
    );

    fmul_pipe_ctrl #(.CNT_W(4)) u_sat (
        .clk(clk), .clrn(clrn),
`ifdef FMUL_PIPE_FLUSH_EN
        .flush(flush),
`endif
        .in_valid(in_valid), .in_ready(s_in_ready), .out_valid(s_out_valid),
        .out_ready(out_ready), .e1(s_e1), .e2(s_e2), .e3(s_e3), .occ(s_occ),
        .stall_cnt(s_stall_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // A stage can advance if downstream accepts or any slot at or after it is empty.
    function automatic bit m_rdy(input int k);
        if (flush) return 1'b0;
        if (out_ready) return 1'b1;
        for (int j = k; j <= 3; j++)
            if (slot[j] < 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_occ();
        int n = 0;
        for (int j = 1; j <= 3; j++)
            if (slot[j] >= 0) n++;
        return n;
    endfunction

    task automatic model_reset();
        for (int j = 1; j <= 3; j++) slot[j] = -1;
        stall = 0;
        retire_exp = next_id;
    endtask

    task automatic model_step();
        bit r1, r2, r3;
        r1 = m_rdy(1); r2 = m_rdy(2); r3 = m_rdy(3);
        if (flush) begin
            for (int j = 1; j <= 3; j++) slot[j] = -1;
            retire_exp = next_id;
        end else begin
            if (slot[3] >= 0 && out_ready) begin
                chk("retire_order", slot[3], retire_exp);
                retire_exp++;
            end
            if (slot[3] >= 0 && !out_ready && stall < 65535) stall++;
            if (r3) slot[3] = slot[2];
            if (r2) slot[2] = slot[1];
            if (r1) begin
                slot[1] = in_valid ? next_id : -1;
                if (in_valid) next_id++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (clrn) model_step();
        #1;
    endtask

    always @(negedge clk) begin
        if (clrn === 1'b1) begin
            chk("in_ready", in_ready, m_rdy(1));
            chk("e1", e1, m_rdy(1));
            chk("e2", e2, m_rdy(2));
            chk("e3", e3, m_rdy(3));
            chk("out_valid", out_valid, slot[3] >= 0);
            chk("occ", occ, m_occ());
            chk("stall_cnt", stall_cnt, stall);
            chk("sat_stall_cnt", s_stall_cnt, (stall > 15) ? 15 : stall);
            chk("sat_occ", s_occ, m_occ());
        end
    end

    task automatic do_reset();
        clrn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        model_reset();
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_occ", occ, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_e123", {e1, e2, e3}, 3'b111);
        chk("rst_stall", stall_cnt, 0);
        tick(); tick();
        clrn = 1'b1;
    endtask

    initial begin
        for (int j = 1; j <= 3; j++) slot[j] = -1;
        do_reset();

        // Streaming: 5 ops back-to-back, downstream always ready.
        in_valid = 1'b1; out_ready = 1'b1; nov = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 3) begin
                chk("stream_occ3", occ, 3);
                chk("stream_first_out", out_valid, 1);
            end
            if (out_valid) nov++;
            in_valid = (i < 5);
        end
        chk("stream_out_cycles", nov, 5);
        chk("stream_stall", stall_cnt, 0);
        chk("stream_drained", occ, 0);

        // Full stall, then saturation on the narrow counter.
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1;
        tick(); tick(); tick();
        chk("full_occ", occ, 3);
        chk("full_stall0", stall_cnt, 0);
        chk("full_in_ready", in_ready, 0);
        chk("full_e123", {e1, e2, e3}, 3'b000);
        for (int i = 0; i < 10; i++) tick();
        chk("stall_10", stall_cnt, 10);
        chk("sat_stall_10", s_stall_cnt, 10);
        for (int i = 0; i < 10; i++) tick();
        chk("stall_20", stall_cnt, 20);
        chk("sat_stall_15", s_stall_cnt, 15);
        out_ready = 1'b1;
        #1;
        chk("full_release_in_ready", in_ready, 1);
        tick();
        chk("full_accept_retire_occ", occ, 3);
        chk("stall_hold_20", stall_cnt, 20);
        in_valid = 1'b0;
        tick(); tick(); tick();
        chk("full_drained", occ, 0);

        // Bubble collapse: A, idle, B, downstream stalled.
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        tick(); in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        tick();
        chk("bubble_occ", occ, 2);
        chk("bubble_out_valid", out_valid, 1);
        chk("bubble_in_ready", in_ready, 1);
        chk("bubble_e2_blocked", e2, 0);

        // Async reset mid-cycle with the pipe full.
        in_valid = 1'b1;
        tick();
        chk("pre_rst_occ", occ, 3);
        #2 clrn = 1'b0;
        model_reset();
        #1;
        chk("async_out_valid", out_valid, 0);
        chk("async_occ", occ, 0);
        chk("async_stall", stall_cnt, 0);
        in_valid = 1'b0;
        tick(); tick();
        clrn = 1'b1;
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        chk("first_after_reset_occ", occ, 1);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("post_rst_drained", occ, 0);

`ifdef FMUL_PIPE_FLUSH_EN
        // Flush beats a simultaneous input and drops both in-flight ops.
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1;
        tick(); tick();
        chk("flush_pre_occ", occ, 2);
        flush = 1'b1;
        #1;
        chk("flush_in_ready", in_ready, 0);
        chk("flush_e1", e1, 0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_occ", occ, 0);
        chk("flush_out_valid", out_valid, 0);
        out_ready = 1'b1; nov = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (out_valid) nov++;
        end
        chk("flush_no_out", nov, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
